// File: rtl/vend_fsm_param.sv
// Coin-operated vending controller: half/one-unit coins, programmable PRICE,
// change and refund paid out as half-unit pulses. Optional sale counter: VEND_SALE_CNT_EN.
module vend_fsm_param #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_change_half,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
`ifdef VEND_SALE_CNT_EN
  ,
  output logic [15:0]         po_sale_cnt
`endif
);

  // state  | meaning
  // IDLE   | no credit held, waiting for coins
  // ACCUM  | 0 < credit < PRICE
  // REFUND | issuing change/refund pulses; coins and cancel ignored

  if (PRICE < 1 || PRICE + 2 > (2 ** CREDIT_W) - 1) begin : g_param_check
    $error("vend_fsm_param: PRICE=%0d does not fit CREDIT_W=%0d", PRICE, CREDIT_W);
  end

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCUM  = 3'b010,
    REFUND = 3'b100
  } state_t;

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W-1:0] CNT_ONE = CREDIT_W'(1);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [CREDIT_W-1:0] chg_cnt, chg_cnt_nxt;
  logic                cola_nxt, change_nxt, busy_nxt;
  logic [CREDIT_W:0]   value, sum, excess;

  always_comb begin
    value       = {{(CREDIT_W - 1){1'b0}}, pi_money_one, pi_money_half};
    sum         = {1'b0, credit} + value;
    excess      = sum - PRICE_X;
    state_nxt   = state;
    credit_nxt  = credit;
    chg_cnt_nxt = chg_cnt;
    cola_nxt    = 1'b0;
    change_nxt  = 1'b0;
    busy_nxt    = 1'b0;

    case (state)
      IDLE, ACCUM: begin
        if (pi_cancel) begin
          // cancel wins over vend; coins arriving alongside it are refunded too
          credit_nxt = '0;
          if (sum != '0) begin
            state_nxt   = REFUND;
            change_nxt  = 1'b1;
            busy_nxt    = 1'b1;
            chg_cnt_nxt = sum[CREDIT_W-1:0] - CNT_ONE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (sum >= PRICE_X) begin
          cola_nxt   = 1'b1;
          credit_nxt = '0;
          if (excess != '0) begin
            state_nxt   = REFUND;
            change_nxt  = 1'b1;
            busy_nxt    = 1'b1;
            chg_cnt_nxt = excess[CREDIT_W-1:0] - CNT_ONE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          credit_nxt = sum[CREDIT_W-1:0];
          state_nxt  = (sum != '0) ? ACCUM : IDLE;
        end
      end

      REFUND: begin
        // chg_cnt holds pulses still owed after the one currently on the output
        credit_nxt = '0;
        if (chg_cnt != '0) begin
          chg_cnt_nxt = chg_cnt - CNT_ONE;
          change_nxt  = 1'b1;
          busy_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        credit_nxt  = '0;
        chg_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= IDLE;
      credit         <= '0;
      chg_cnt        <= '0;
      po_cola        <= 1'b0;
      po_change_half <= 1'b0;
      po_busy        <= 1'b0;
    end else begin
      state          <= state_nxt;
      credit         <= credit_nxt;
      chg_cnt        <= chg_cnt_nxt;
      po_cola        <= cola_nxt;
      po_change_half <= change_nxt;
      po_busy        <= busy_nxt;
    end
  end

  assign po_credit = credit;

`ifdef VEND_SALE_CNT_EN
  logic [15:0] sale_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sale_cnt <= '0;
    end else if (cola_nxt && sale_cnt != 16'hFFFF) begin
      sale_cnt <= sale_cnt + 16'd1;
    end
  end

  assign po_sale_cnt = sale_cnt;
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: directed scenarios with literal
// expectations plus randomized traffic against a timeline-based credit model.
module tb_vend_fsm_param;

  localparam int PRICE    = 5;
  localparam int CREDIT_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                half = 1'b0, one = 1'b0, cancel = 1'b0;
  logic                cola, change_half, busy;
  logic [CREDIT_W-1:0] credit;
`ifdef VEND_SALE_CNT_EN
  logic [15:0]         sale_cnt;
`endif

  vend_fsm_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .pi_money_half  (half),
    .pi_money_one   (one),
    .pi_cancel      (cancel),
    .po_cola        (cola),
    .po_change_half (change_half),
    .po_busy        (busy),
    .po_credit      (credit)
`ifdef VEND_SALE_CNT_EN
    ,
    .po_sale_cnt    (sale_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: credit as an integer, payout as the edge index of the last pulse.
  int edge_no  = 0;
  int pay_last = -1;
  int m_credit = 0;
  bit valid    = 0;
  int x_cola = 0, x_chg = 0, x_busy = 0, x_credit = 0;
  int x_sale = 0;

  always @(posedge clk) begin
    int sum, k;
    edge_no++;
    if (rst) begin
      m_credit = 0; pay_last = -1;
      x_cola = 0; x_chg = 0; x_busy = 0; x_credit = 0; x_sale = 0;
      valid = 1;
    end else begin
      x_cola = 0;
      // coins and cancel count only if the output was not busy before this edge
      if (edge_no - 1 > pay_last) begin
        sum = m_credit + int'(half) + 2 * int'(one);
        k = 0;
        if (cancel) begin
          k = sum; m_credit = 0;
        end else if (sum >= PRICE) begin
          k = sum - PRICE; m_credit = 0; x_cola = 1;
        end else begin
          m_credit = sum;
        end
        if (k > 0) pay_last = edge_no + k - 1;
      end
      x_chg    = (edge_no <= pay_last) ? 1 : 0;
      x_busy   = x_chg;
      x_credit = m_credit;
      if (x_cola == 1 && x_sale != 65535) x_sale = x_sale + 1;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("cola",   int'(cola),        x_cola);
      chk("change", int'(change_half), x_chg);
      chk("busy",   int'(busy),        x_busy);
      chk("credit", int'(credit),      x_credit);
`ifdef VEND_SALE_CNT_EN
      chk("sale_cnt", int'(sale_cnt),  x_sale);
`endif
    end
  end

  task automatic step(input logic h, input logic o, input logic c, input logic r);
    half = h; one = o; cancel = c; rst = r;
    @(posedge clk);
    #1;
    half = 1'b0; one = 1'b0; cancel = 1'b0; rst = 1'b0;
  endtask

  task automatic outs(input string name, input int c, input int ch, input int b, input int cr);
    chk({name, ".cola"},   int'(cola),        c);
    chk({name, ".change"}, int'(change_half), ch);
    chk({name, ".busy"},   int'(busy),        b);
    chk({name, ".credit"}, int'(credit),      cr);
  endtask

  task automatic halves(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    #1;
    step(0, 0, 0, 1);
    outs("reset", 0, 0, 0, 0);

    // exact price, five half coins
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      outs("exact_acc", 0, 0, 0, i);
    end
    step(1, 0, 0, 0);
    outs("exact_vend", 1, 0, 0, 0);
    step(0, 0, 0, 0);
    outs("exact_after", 0, 0, 0, 0);

    // overpay by one half-unit
    halves(4);
    step(0, 1, 0, 0);
    outs("over_vend", 1, 1, 1, 0);
    step(0, 0, 0, 0);
    outs("over_after", 0, 0, 0, 0);

    // both coins together, two change pulses
    halves(4);
    step(1, 1, 0, 0);
    outs("both_vend", 1, 1, 1, 0);
    step(0, 0, 0, 0);
    outs("both_chg2", 0, 1, 1, 0);
    step(0, 0, 0, 0);
    outs("both_after", 0, 0, 0, 0);

    // cancel with a coin: five refund pulses, injected coin lost
    halves(3);
    step(0, 1, 1, 0);
    outs("cancel_1", 0, 1, 1, 0);
    step(1, 0, 0, 0);
    outs("cancel_2", 0, 1, 1, 0);
    for (int i = 3; i <= 5; i++) begin
      step(0, 0, 0, 0);
      outs("cancel_n", 0, 1, 1, 0);
    end
    step(0, 0, 0, 0);
    outs("cancel_after", 0, 0, 0, 0);

    // cancel with nothing held does nothing
    step(0, 0, 1, 0);
    outs("cancel_empty", 0, 0, 0, 0);

    // reset mid-refund
    halves(4);
    step(0, 1, 0, 0);
    outs("rst_refund_vend", 1, 1, 1, 0);
    step(0, 0, 0, 1);
    outs("rst_refund", 0, 0, 0, 0);
    halves(4);
    step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    outs("rst_refund2", 0, 0, 0, 0);
    step(0, 0, 0, 0);
    outs("rst_refund2_after", 0, 0, 0, 0);

`ifdef VEND_SALE_CNT_EN
    force dut.sale_cnt = 16'hFFFE;
    x_sale = 65534;
    #1;
    release dut.sale_cnt;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
    end
    chk("sale_sat", int'(sale_cnt), 65535);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("sale_cancel", int'(sale_cnt), 65535);
    repeat (3) step(0, 0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised coin-operated vending controller; successor to the single-coin three-state cola FSM.
- Accepts half-unit and one-unit coins and vends when accumulated credit reaches a programmable PRICE.
- Returns change as a train of half-unit pulses and supports cancel/refund.
- Sits between the debounced coin/key input logic and the LED/actuator drivers on the board.

Parameters:
- PRICE, 5, item price in half-units (5 = 2.5 units); legal range 1..(2^CREDIT_W - 3).
- CREDIT_W, 4, width of the credit and change counters; must hold PRICE+2.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  synchronous, active-high reset
- pi_money_half  input  1  single-cycle pulse: one half-unit coin inserted
- pi_money_one  input  1  single-cycle pulse: one full-unit coin inserted (worth 2 half-units)
- pi_cancel  input  1  single-cycle pulse: abort purchase, refund credit
- po_cola  output  1  one-cycle vend pulse
- po_change_half  output  1  one pulse per half-unit returned (change or refund)
- po_busy  output  1  high while change/refund pulses are being issued; coins ignored
- po_credit  output  CREDIT_W  current accumulated credit in half-units

Behaviour:
- Reset (sys_rst=1 at a rising edge): state IDLE, credit=0, change counter=0; po_cola, po_change_half, po_busy = 0; po_credit = 0. Reset overrides everything, including mid-refund; pending change is discarded.
- States: IDLE (credit=0), ACCUM (0<credit<PRICE), REFUND (change counter>0). Encoding is one-hot; an illegal state recovers to IDLE with credit cleared.
- Coin value per edge: v = pi_money_half + 2*pi_money_one. Both coins asserted together give v=3.
- In IDLE/ACCUM at edge N, with sum = credit + v:
  - pi_cancel=1: refund k = sum (cancel beats vend; coins in the same cycle are refunded). No vend. Credit becomes 0. If k=0 there is no effect and the FSM stays in IDLE.
  - else if sum >= PRICE: po_cola=1 in cycle N+1 only. Credit becomes 0. Change k = sum - PRICE (0..2).
  - else: credit = sum; state is ACCUM if sum>0, else IDLE.
- Payout:
  - When k>0, po_change_half is high in cycles N+1..N+k (k consecutive cycles). po_busy is high in the same cycles. State is REFUND during them, then IDLE.
  - po_cola and the first change pulse coincide in cycle N+1.
- In REFUND: pi_money_half, pi_money_one and pi_cancel are ignored (coins lost by design; upstream must honour po_busy).
- po_credit is registered and reflects the credit after each edge; it reads 0 in REFUND.
- All outputs are registered; latency from input pulse to response is exactly 1 cycle.
- Elaboration: if PRICE+2 exceeds 2^CREDIT_W - 1, raise an error via a generate-time check.

Optional Feature:
- Macro: VEND_SALE_CNT_EN.
- Defined: adds output port po_sale_cnt [15:0].
  - Reset to 0.
  - Increments by 1 in the cycle po_cola is asserted.
  - Saturates at 16'hFFFF (no wrap).
  - Unaffected by cancel.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-refund: PRICE=5, credit 4, pulse pi_money_one (k=1); assert sys_rst in the next cycle -> all outputs 0 after that edge, no further change pulses.
- Exact price: PRICE=5, five pi_money_half pulses on separate cycles -> po_credit 1,2,3,4 after each of the first four; po_cola high one cycle after the 5th coin; no change pulses; po_busy stays 0.
- Overpay: PRICE=5, credit 4, pulse pi_money_one -> po_cola and po_change_half high together 1 cycle later; po_busy high for that 1 cycle only.
- Both coins plus change: credit 4, pi_money_half and pi_money_one in the same cycle (sum 7) -> po_cola 1 cycle, then po_change_half high for exactly 2 consecutive cycles starting with the vend cycle; po_busy matches.
- Cancel with coins: credit 3, pi_cancel together with pi_money_one -> no po_cola; 5 consecutive po_change_half pulses; a pi_money_half injected during the pulses is ignored and po_credit reads 0 afterwards.
- VEND_SALE_CNT_EN defined: force po_sale_cnt to 16'hFFFE, perform 3 vends -> reads 16'hFFFF and holds; a cancel leaves it unchanged.
